// File: rtl/morse_key_timer_if.sv
// Bundle of the key input and the classification/strobe outputs of the
// Morse key timer. The slave modport is the timer itself; the master
// modport is whoever drives the key and consumes the strobes.
interface morse_key_timer_if #(
  parameter int MAX_SYMS = 5
);
  logic                key_in;
  logic                sym_valid;
  logic                sym_dash;
  logic                letter_valid;
  logic [MAX_SYMS-1:0] letter_code;
  logic [2:0]          letter_len;
  logic                word_gap;
  logic                busy;
  logic                err;

  modport master (
    output key_in,
    input  sym_valid, sym_dash, letter_valid, letter_code, letter_len,
    input  word_gap, busy, err
  );

  modport slave (
    input  key_in,
    output sym_valid, sym_dash, letter_valid, letter_code, letter_len,
    output word_gap, busy, err
  );
endinterface

// File: rtl/morse_key_timer.sv
// Morse key timer: measures the debounced key level in dot units, classifies
// each press as dot or dash, collects symbols into a letter code and flags
// letter and word boundaries from the release length. All strobes are
// registered one-cycle pulses.
// Optional build macro MORSE_OVERFLOW_ERR_EN: when defined, err pulses with
// letter_valid for letters that had more than MAX_SYMS symbols entered;
// otherwise err is tied low and such letters are truncated silently.
module morse_key_timer #(
  parameter int TICK_DIV   = 50000,
  parameter int DASH_UNITS = 2,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7,
  parameter int MAX_SYMS   = 5,
  parameter int CNT_W      = 8
) (
  input logic              clk_fast,
  input logic              rst,
  morse_key_timer_if.slave bus
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRESC_W-1:0]  TICK_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]    DASH_U    = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0]    LETTER_U  = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0]    WORD_U    = CNT_W'(WORD_GAP);
  localparam logic [2:0]          MAX_L     = 3'(MAX_SYMS);
  localparam logic [MAX_SYMS-1:0] SYM_ONE   = MAX_SYMS'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS     = 2'd1,
    GAP       = 2'd2,
    WAIT_WORD = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 key_q;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]     units_q, units_d;
  logic [MAX_SYMS-1:0]  acc_code_q, acc_code_d;
  logic [2:0]           acc_len_q, acc_len_d;

  logic                 sym_valid_q, sym_valid_d;
  logic                 sym_dash_q, sym_dash_d;
  logic                 letter_valid_q, letter_valid_d;
  logic [MAX_SYMS-1:0]  letter_code_q, letter_code_d;
  logic [2:0]           letter_len_q, letter_len_d;
  logic                 word_gap_q, word_gap_d;

  // Edge and tick decode. An edge resets the time base, so a tick landing
  // on an edge cycle is discarded (edge wins).
  logic             key_edge, key_rise, key_fall, tick, tick_eff, is_dash;
  logic [CNT_W-1:0] units_inc;

  assign key_edge  = bus.key_in != key_q;
  assign key_rise  = key_edge & bus.key_in;
  assign key_fall  = key_edge & ~bus.key_in;
  assign tick      = presc_q == TICK_LAST;
  assign tick_eff  = tick & ~key_edge;
  assign units_inc = (&units_q) ? units_q : units_q + 1'b1;
  assign is_dash   = units_q >= DASH_U;

`ifdef MORSE_OVERFLOW_ERR_EN
  logic ovf_q, ovf_d;
  logic err_q, err_d;
`endif

  // Next-state logic: time base, symbol accumulator and strobe generation.
  always_comb begin
    state_d        = state_q;
    presc_d        = (key_edge || tick) ? '0 : presc_q + 1'b1;
    units_d        = units_q;
    acc_code_d     = acc_code_q;
    acc_len_d      = acc_len_q;
    sym_valid_d    = 1'b0;
    sym_dash_d     = sym_dash_q;
    letter_valid_d = 1'b0;
    letter_code_d  = letter_code_q;
    letter_len_d   = letter_len_q;
    word_gap_d     = 1'b0;
`ifdef MORSE_OVERFLOW_ERR_EN
    ovf_d          = ovf_q;
    err_d          = 1'b0;
`endif

    if (key_edge) begin
      units_d = '0;
    end else if (tick) begin
      units_d = units_inc;
    end

    case (state_q)
      IDLE: begin
        if (key_rise) state_d = PRESS;
      end
      PRESS: begin
        if (key_fall) begin
          sym_valid_d = 1'b1;
          sym_dash_d  = is_dash;
          if (acc_len_q < MAX_L) begin
            acc_code_d = acc_code_q | (is_dash ? (SYM_ONE << acc_len_q) : '0);
            acc_len_d  = acc_len_q + 3'd1;
          end else begin
`ifdef MORSE_OVERFLOW_ERR_EN
            ovf_d = 1'b1;
`endif
          end
          state_d = GAP;
        end
      end
      GAP: begin
        if (key_rise) begin
          state_d = PRESS;
        end else if (tick_eff && units_inc == LETTER_U) begin
          letter_valid_d = 1'b1;
          letter_code_d  = acc_code_q;
          letter_len_d   = acc_len_q;
          acc_code_d     = '0;
          acc_len_d      = '0;
`ifdef MORSE_OVERFLOW_ERR_EN
          err_d          = ovf_q;
          ovf_d          = 1'b0;
`endif
          state_d        = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (key_rise) begin
          state_d = PRESS;
        end else if (tick_eff && units_inc == WORD_U) begin
          word_gap_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any partial letter.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      key_q          <= 1'b0;
      presc_q        <= '0;
      units_q        <= '0;
      acc_code_q     <= '0;
      acc_len_q      <= '0;
      sym_valid_q    <= 1'b0;
      sym_dash_q     <= 1'b0;
      letter_valid_q <= 1'b0;
      letter_code_q  <= '0;
      letter_len_q   <= '0;
      word_gap_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_q          <= bus.key_in;
      presc_q        <= presc_d;
      units_q        <= units_d;
      acc_code_q     <= acc_code_d;
      acc_len_q      <= acc_len_d;
      sym_valid_q    <= sym_valid_d;
      sym_dash_q     <= sym_dash_d;
      letter_valid_q <= letter_valid_d;
      letter_code_q  <= letter_code_d;
      letter_len_q   <= letter_len_d;
      word_gap_q     <= word_gap_d;
    end
  end

`ifdef MORSE_OVERFLOW_ERR_EN
  // Overflow flag for the letter in progress and its error strobe.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.sym_valid    = sym_valid_q;
  assign bus.sym_dash     = sym_dash_q;
  assign bus.letter_valid = letter_valid_q;
  assign bus.letter_code  = letter_code_q;
  assign bus.letter_len   = letter_len_q;
  assign bus.word_gap     = word_gap_q;
  assign bus.busy         = state_q != IDLE;

endmodule

// File: doc/morse_key_timer.md
Name: morse_key_timer

Overview:
- Sequencing controller behind the key debouncer in the Morse decoder.
- Times the debounced key level in dot units and classifies each press as dot or dash.
- Accumulates symbols into a letter code and flags letter and word boundaries from release duration.
- Feeds the letter lookup/display stage with one-cycle strobes.

Parameters:
TICK_DIV, 50000, clk_fast cycles per dot unit (>=2)
DASH_UNITS, 2, press length in units at or above which the symbol is a dash
LETTER_GAP, 3, release length in units that closes a letter
WORD_GAP, 7, release length in units that signals a word gap (> LETTER_GAP)
MAX_SYMS, 5, maximum symbols per letter
CNT_W, 8, unit counter width (saturating)

Ports:
clk_fast  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
key_in  in  1  debounced key level, 1 = pressed
sym_valid  out  1  one-cycle strobe, symbol classified
sym_dash  out  1  symbol type for the current sym_valid (1 = dash), held until the next strobe
letter_valid  out  1  one-cycle strobe, letter complete
letter_code  out  MAX_SYMS  bit i = symbol i (bit0 first, 1 = dash), unused bits 0, held until the next letter_valid
letter_len  out  3  symbol count of letter_code (1..MAX_SYMS), held until the next letter_valid
word_gap  out  1  one-cycle strobe, word boundary
busy  out  1  1 when state != IDLE
err  out  1  one-cycle overflow strobe (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; key_q=0; prescaler=0; units=0; accumulator cleared.
  - All outputs 0, including letter_code and letter_len.
- Edge detect: key_q registers key_in. An edge is any cycle with key_in != key_q.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 when prescaler==TICK_DIV-1.
  - Cleared to 0 on every edge.
- units:
  - Increments on tick and saturates at 2^CNT_W-1.
  - Cleared on every edge.
  - Edge and tick in the same cycle: edge wins (clear).
- Timing: the Nth tick after an edge falls N*TICK_DIV cycles after the edge cycle. All strobes are registered and appear the cycle after the triggering edge or tick.
- States:
  - IDLE: rising edge -> PRESS.
  - PRESS: falling edge -> classify (units >= DASH_UNITS ? dash : dot).
    - Pulse sym_valid and update sym_dash.
    - If len < MAX_SYMS: code[len] <= dash and len <= len+1; else set the overflow flag and drop the symbol.
    - Go to GAP.
    - A release before the first tick (units=0) is a dot.
  - GAP:
    - Rising edge -> PRESS (same letter).
    - Tick making units == LETTER_GAP -> pulse letter_valid, latch letter_code/letter_len, clear accumulator and overflow flag -> WAIT_WORD.
  - WAIT_WORD:
    - Tick making units == WORD_GAP -> pulse word_gap -> IDLE.
    - Rising edge first -> PRESS; no word_gap is emitted.
- At most one strobe type per cycle. letter_valid and word_gap are each issued exactly once per gap.
- Key held through reset deassert: key_q=0, so the first cycle sees a rising edge -> PRESS.
- rst mid-letter: accumulated symbols are discarded and no letter_valid is issued.
- Key held indefinitely: units saturates with no wrap; classified as dash on release.

Optional Feature:
- Macro: MORSE_OVERFLOW_ERR_EN.
- Defined: err pulses in the same cycle as letter_valid when more than MAX_SYMS symbols were entered. letter_code/letter_len carry the first MAX_SYMS symbols.
- Undefined: err tied to 0. Overflowing letters are emitted the same way, truncated silently.

Test Plan:
- TICK_DIV=4, defaults. Reset, key idle 40 cycles -> all outputs 0, busy=0, no strobes.
- Press 4 cycles, release -> sym_valid=1 one cycle, sym_dash=0. Press 12 cycles, release -> sym_dash=1. Press 2 cycles (units=0) -> dot.
- "A": dot, release 4 cycles, dash, release 12 cycles -> single letter_valid, letter_code=5'b00010, letter_len=2; then release to 28 cycles after the last edge -> one word_gap, busy=0.
- Release 20 cycles after a letter, then press -> letter_valid only, no word_gap, state PRESS.
- Six dots, each separated by 4-cycle gaps, then a letter gap -> letter_len=5, letter_code=0. err=1 with MORSE_OVERFLOW_ERR_EN, err=0 without.
- Assert rst during the third symbol's press -> outputs 0 immediately. Key still held at deassert -> PRESS entered. Release 4 cycles later -> dot with letter_len=1 at the next letter gap.
